fp_exception_ctrl: RTL and testbench

FP_EXCEPTION_CTRL -- requirements
Module: fp_exception_ctrl

---
 rtl/fp_exception_ctrl_pkg.sv | 20 ++
 rtl/fp_exception_ctrl_prio.sv | 24 ++
 rtl/fp_exception_ctrl.sv | 122 ++++++++++++
 tb/tb_fp_exception_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_exception_ctrl_pkg.sv
// Shared definitions for the floating-point exception controller:
// exception source indices, default source count and the request FSM encoding.
package fp_exception_ctrl_pkg;

  localparam int N_SRC_DEFAULT = 6;

  localparam int SRC_SNAN      = 0;
  localparam int SRC_DIV_ZERO  = 1;
  localparam int SRC_OVERFLOW  = 2;
  localparam int SRC_UNDERFLOW = 3;
  localparam int SRC_INEXACT   = 4;
  localparam int SRC_QNAN      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/fp_exception_ctrl_prio.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set bit.
module fp_exc_prio_enc
  import fp_exception_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    any = |req;
    idx = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/fp_exception_ctrl.sv
// Floating-point exception controller: sticky status, overrun and saturating
// occurrence counters per source, with a masked, fixed-priority interrupt request.
module fp_exception_ctrl
  import fp_exception_ctrl_pkg::*;
#(
  parameter int               N_SRC    = N_SRC_DEFAULT,
  parameter int               CNT_W    = 8,
  parameter logic [N_SRC-1:0] MASK_RST = '0,
  localparam int              ID_W     = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             interrupt_reset,
  input  logic             flag_valid,
  input  logic [N_SRC-1:0] flag_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             clr_we,
  input  logic [N_SRC-1:0] clr_wdata,
  input  logic             irq_ack,
  input  logic [ID_W-1:0]  cnt_sel,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] status,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] overrun,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [N_SRC-1:0]   status_q, status_d;
  logic [N_SRC-1:0]   overrun_q, overrun_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q [N_SRC];
  logic [CNT_W-1:0]   cnt_d [N_SRC];

  logic [N_SRC-1:0]   set_vec, ack_vec, wclr_vec, clr_vec, pending;
  logic               pend_any;
  logic [ID_W-1:0]    pend_idx;

  // Sticky state update: a new flag always wins over a clear of the same bit.
  always_comb begin
    set_vec  = flag_valid ? flag_in : '0;
    wclr_vec = clr_we ? clr_wdata : '0;
    ack_vec  = '0;
    if (state_q == ST_REQ && irq_ack) ack_vec[irq_id_q] = 1'b1;
    clr_vec   = ack_vec | wclr_vec;
    status_d  = (status_q & ~clr_vec) | set_vec;
    overrun_d = (overrun_q & ~clr_vec) | (set_vec & status_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
    for (int i = 0; i < N_SRC; i++) begin
      // NOTE: blocking assignments here are evaluated in order, so the increment sees the already-cleared value.
      cnt_d[i] = wclr_vec[i] ? '0 : cnt_q[i];
      if (set_vec[i] && cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + 1'b1;
    end
  end

  assign pending = status_q & ~mask_q;

  fp_exc_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req (pending),
    .any (pend_any),
    .idx (pend_idx)
  );

  // GAP holds irq low for its one cycle and then arbitrates like IDLE, so a
  // source still pending is re-requested without a second idle cycle.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pend_any) begin
          state_d  = ST_REQ;
          irq_id_d = pend_idx;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack || !status_d[irq_id_q] || mask_d[irq_id_q]) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (interrupt_reset) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      status_q  <= '0;
      overrun_q <= '0;
      mask_q    <= MASK_RST;
      // NOTE: the counters are ordinary flops, not a RAM, so they are cleared by reset like the rest of the state.
      cnt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      status_q  <= status_d;
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < N_SRC) cnt_out = cnt_q[cnt_sel];
  end

  assign irq     = (state_q == ST_REQ);
  assign irq_id  = irq_id_q;
  assign status  = status_q;
  assign mask    = mask_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fp_exception_ctrl.sv
// Self-checking bench for fp_exception_ctrl: expected interrupt ids are queued
// as stimulus is driven and popped when the DUT raises irq.
module tb_fp_exception_ctrl;

  localparam int               N_SRC    = 6;
  localparam int               CNT_W    = 4;
  localparam logic [N_SRC-1:0] MASK_RST = 6'b100000;
  localparam int               ID_W     = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1;

  logic             clk = 1'b0;
  logic             interrupt_reset;
  logic             flag_valid;
  logic [N_SRC-1:0] flag_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             clr_we;
  logic [N_SRC-1:0] clr_wdata;
  logic             irq_ack;
  logic [ID_W-1:0]  cnt_sel;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] status;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] overrun;
  logic [CNT_W-1:0] cnt_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  fp_exception_ctrl #(
    .N_SRC    (N_SRC),
    .CNT_W    (CNT_W),
    .MASK_RST (MASK_RST)
  ) dut (
    .clk             (clk),
    .interrupt_reset (interrupt_reset),
    .flag_valid      (flag_valid),
    .flag_in         (flag_in),
    .mask_we         (mask_we),
    .mask_wdata      (mask_wdata),
    .clr_we          (clr_we),
    .clr_wdata       (clr_wdata),
    .irq_ack         (irq_ack),
    .cnt_sel         (cnt_sel),
    .irq             (irq),
    .irq_id          (irq_id),
    .status          (status),
    .mask            (mask),
    .overrun         (overrun),
    .cnt_out         (cnt_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    interrupt_reset = 1'b0;
    flag_valid = 1'b0; flag_in = '0;
    mask_we = 1'b0;    mask_wdata = '0;
    clr_we = 1'b0;     clr_wdata = '0;
    irq_ack = 1'b0;
  endtask

  task automatic pulse_flag(input logic [N_SRC-1:0] f);
    flag_valid = 1'b1; flag_in = f;
    tick();
    flag_valid = 1'b0; flag_in = '0;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  // Waits up to max_wait cycles for irq, then pops the scoreboard and compares irq_id.
  task automatic expect_irq(input string name, input int max_wait, output int waited);
    int exp;
    waited = 0;
    while (irq !== 1'b1 && waited < max_wait) begin
      tick();
      waited++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s irq: got %b after %0d cycles, expected 1", name, irq, waited);
    end else if (exp < 0) begin
      tests_failed++;
      $display("FAIL %s scoreboard: irq_id=%0d raised with nothing expected", name, irq_id);
    end else if (irq_id !== ID_W'(exp)) begin
      tests_failed++;
      $display("FAIL %s irq_id: got %0d, expected %0d", name, irq_id, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    cnt_sel = '0;
    interrupt_reset = 1'b1;
    tick(); tick();
    interrupt_reset = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset irq: got %b, expected 0", irq); end
    tests_run++; if (irq_id !== '0) begin tests_failed++; $display("FAIL reset irq_id: got %0d, expected 0", irq_id); end
    tests_run++; if (status !== '0) begin tests_failed++; $display("FAIL reset status: got %b, expected 0", status); end
    tests_run++; if (overrun !== '0) begin tests_failed++; $display("FAIL reset overrun: got %b, expected 0", overrun); end
    tests_run++; if (mask !== MASK_RST) begin tests_failed++; $display("FAIL reset mask: got %b, expected %b", mask, MASK_RST); end
    tests_run++; if (cnt_out !== '0) begin tests_failed++; $display("FAIL reset cnt_out: got %0d, expected 0", cnt_out); end
  endtask

  task automatic test_single_event();
    int w;
    pulse_flag(6'b000010);
    exp_q.push_back(1);
    tests_run++; if (status !== 6'b000010) begin tests_failed++; $display("FAIL single status: got %b, expected 000010", status); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL single early irq: got %b, expected 0", irq); end
    tick();
    expect_irq("single", 0, w);
    tick();
    tests_run++; if (irq !== 1'b1 || irq_id !== 3'd1) begin tests_failed++; $display("FAIL single hold: irq=%b id=%0d, expected 1/1", irq, irq_id); end
    ack_once();
    tests_run++; if (status !== '0) begin tests_failed++; $display("FAIL single ack status: got %b, expected 0", status); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL single ack irq: got %b, expected 0", irq); end
    cnt_sel = 3'd1;
    #1;
    tests_run++; if (cnt_out !== 4'd1) begin tests_failed++; $display("FAIL single count: got %0d, expected 1", cnt_out); end
    tick();
  endtask

  task automatic test_priority_gap();
    int w;
    pulse_flag(6'b010100);
    exp_q.push_back(2);
    exp_q.push_back(4);
    tick();
    expect_irq("prio first", 0, w);
    ack_once();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio gap irq: got %b, expected 0", irq); end
    tests_run++; if (status !== 6'b010000) begin tests_failed++; $display("FAIL prio gap status: got %b, expected 010000", status); end
    tick();
    expect_irq("prio second", 0, w);
    ack_once();
    tick();
    tests_run++; if (irq !== 1'b0 || status !== '0) begin tests_failed++; $display("FAIL prio idle: irq=%b status=%b, expected 0/000000", irq, status); end
  endtask

  task automatic test_mask_withdraw();
    int w;
    pulse_flag(6'b001000);
    exp_q.push_back(3);
    tick();
    expect_irq("mask raise", 0, w);
    mask_we = 1'b1; mask_wdata = 6'b101000;
    tick();
    mask_we = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mask withdraw irq: got %b, expected 0", irq); end
    tests_run++; if (status !== 6'b001000) begin tests_failed++; $display("FAIL mask status kept: got %b, expected 001000", status); end
    tests_run++; if (mask !== 6'b101000) begin tests_failed++; $display("FAIL mask value: got %b, expected 101000", mask); end
    tick();
    ack_once();
    tests_run++; if (irq !== 1'b0 || status !== 6'b001000) begin tests_failed++; $display("FAIL mask idle ack: irq=%b status=%b, expected 0/001000", irq, status); end
    mask_we = 1'b1; mask_wdata = 6'b100000;
    tick();
    mask_we = 1'b0;
    exp_q.push_back(3);
    expect_irq("mask unmask", 3, w);
    tests_run++; if (w != 1) begin tests_failed++; $display("FAIL mask unmask latency: got %0d, expected 1", w); end
    ack_once();
    tick();
  endtask

  task automatic test_collision();
    int w;
    clr_we = 1'b1; clr_wdata = '1;
    tick();
    clr_we = 1'b0; clr_wdata = '0;
    pulse_flag(6'b000010);
    exp_q.push_back(1);
    tick();
    expect_irq("collide first", 0, w);
    irq_ack = 1'b1;
    pulse_flag(6'b000010);
    irq_ack = 1'b0;
    cnt_sel = 3'd1;
    #1;
    tests_run++; if (status !== 6'b000010) begin tests_failed++; $display("FAIL collide status: got %b, expected 000010", status); end
    tests_run++; if (overrun !== 6'b000010) begin tests_failed++; $display("FAIL collide overrun: got %b, expected 000010", overrun); end
    tests_run++; if (cnt_out !== 4'd2) begin tests_failed++; $display("FAIL collide count: got %0d, expected 2", cnt_out); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL collide gap irq: got %b, expected 0", irq); end
    exp_q.push_back(1);
    tick();
    expect_irq("collide reraise", 0, w);
    ack_once();
    tests_run++; if (overrun !== '0 || status !== '0) begin tests_failed++; $display("FAIL collide clear: status=%b overrun=%b, expected 0/0", status, overrun); end
    tick();
  endtask

  task automatic test_saturation();
    int w;
    cnt_sel = 3'd4;
    flag_valid = 1'b1; flag_in = 6'b010000;
    for (int i = 0; i < 20; i++) tick();
    flag_valid = 1'b0; flag_in = '0;
    tests_run++; if (cnt_out !== 4'd15) begin tests_failed++; $display("FAIL sat count: got %0d, expected 15", cnt_out); end
    tests_run++; if (overrun !== 6'b010000) begin tests_failed++; $display("FAIL sat overrun: got %b, expected 010000", overrun); end
    exp_q.push_back(4);
    expect_irq("sat irq", 0, w);
    for (int s = N_SRC; s < (1 << ID_W); s++) begin
      cnt_sel = ID_W'(s);
      #1;
      tests_run++; if (cnt_out !== '0) begin tests_failed++; $display("FAIL sel range %0d: got %0d, expected 0", s, cnt_out); end
    end
    cnt_sel = 3'd4;
    clr_we = 1'b1; clr_wdata = 6'b010000;
    tick();
    clr_we = 1'b0; clr_wdata = '0;
    tests_run++; if (cnt_out !== '0) begin tests_failed++; $display("FAIL sat clear count: got %0d, expected 0", cnt_out); end
    tests_run++; if (status !== '0 || overrun !== '0) begin tests_failed++; $display("FAIL sat clear flags: status=%b overrun=%b, expected 0/0", status, overrun); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL sat clear withdraw: got %b, expected 0", irq); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    int w;
    mask_we = 1'b1; mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    pulse_flag(6'b000001);
    exp_q.push_back(0);
    expect_irq("rst raise", 3, w);
    interrupt_reset = 1'b1;
    irq_ack = 1'b1;
    flag_valid = 1'b1; flag_in = '1;
    mask_we = 1'b1; mask_wdata = 6'b010101;
    tick();
    idle_inputs();
    cnt_sel = 3'd0;
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL rst mid irq: got %b, expected 0", irq); end
    tests_run++; if (status !== '0 || overrun !== '0) begin tests_failed++; $display("FAIL rst mid flags: status=%b overrun=%b, expected 0/0", status, overrun); end
    tests_run++; if (mask !== MASK_RST) begin tests_failed++; $display("FAIL rst mid mask: got %b, expected %b", mask, MASK_RST); end
    tests_run++; if (cnt_out !== '0 || irq_id !== '0) begin tests_failed++; $display("FAIL rst mid cnt/id: cnt=%0d id=%0d, expected 0/0", cnt_out, irq_id); end
    tick(); tick();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL rst mid later irq: got %b, expected 0", irq); end
  endtask

  initial begin
    idle_inputs();
    cnt_sel = '0;
    test_reset();
    test_single_event();
    test_priority_gap();
    test_mask_withdraw();
    test_collision();
    test_saturation();
    test_reset_mid_req();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: %0d ids left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
